door_sensor_fsm: RTL and testbench
==================================

# door_sensor_fsm

Front-end stage for the branch queue counter: turns two raw door photo-beam sensors into clean, single-cycle PUSH_UP / PUSH_DOWN pulses. Each sensor is synchronized and debounced. A direction-sequencing FSM then decides whether a customer fully entered or fully exited. Its outputs drive the queue counter's PUSH_UP and PUSH_DOWN inputs directly.

## Interface
- DEB_CYCLES, default 4: consecutive stable synchronized samples required before a debounced level changes. Legal range is 1 to 255.
- TIMEOUT_CYCLES, default 255: maximum cycles the FSM may stay in any non-IDLE, non-WAIT_CLEAR state before it aborts. Used only with DOOR_FAULT_EN.
- clk  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- SENSOR_OUT  input  1  outer beam, asynchronous; 1 means blocked.
- SENSOR_IN  input  1  inner beam, asynchronous; 1 means blocked.
- PUSH_UP  output  1  one-cycle pulse, one customer entered.
- PUSH_DOWN  output  1  one-cycle pulse, one customer exited.
- FAULT  output  1  one-cycle pulse on a sequence timeout. Tied 0 without DOOR_FAULT_EN.

## Operation
- **Synchronizer:** two-flop synchronizer per sensor. Outputs are out_s and in_s.
- **Debounce, per sensor:**
  - The debounced level deb is updated from a counter cnt.
  - If sync value == deb, cnt clears to 0.
  - Otherwise cnt increments. On the edge where cnt would reach DEB_CYCLES, deb takes the sync value and cnt clears.
  - cnt width is $clog2(DEB_CYCLES+1).
- **FSM states:** IDLE, O1, OI_E, I2, I1, OI_X, O2, WAIT_CLEAR. Below, O = deb outer and I = deb inner.
- **IDLE:**
  - O & !I → O1.
  - !O & I → I1.
  - O & I → WAIT_CLEAR (ambiguous, no pulse).
- **Entry path:**
  - O1: O & I → OI_E; !O & !I → IDLE (backed out).
  - OI_E: !O & I → I2; O & !I → O1; both clear → WAIT_CLEAR path rule below.
  - I2: !I & !O → IDLE with a PUSH_UP pulse; O & I → OI_E.
- **Exit path:** mirror of entry.
  - I1: O & I → OI_X; both clear → IDLE.
  - OI_X: O & !I → O2; !O & I → I1.
  - O2: both clear → IDLE with a PUSH_DOWN pulse; O & I → OI_X.
- **Both beams clearing on the same cycle from OI_E or OI_X:** go to IDLE with no pulse. The direction is unresolved.
- **WAIT_CLEAR:** stay until !O & !I, then → IDLE. No pulse is ever generated from this state.
- **Output registers:** PUSH_UP, PUSH_DOWN and FAULT are registered. They are high for exactly one cycle after the transition edge. PUSH_UP and PUSH_DOWN are never high together.
- **At most one pulse per pass:** a customer produces at most one pulse. Oscillating within a path never double-counts.
- **Reset values:** all sync flops 0, deb 0, cnt 0, state IDLE, timeout counter 0, PUSH_UP=0, PUSH_DOWN=0, FAULT=0.
- **Reset mid-sequence:** discards the partial passage; no pulse is emitted.

## Timing
- **Raw-to-debounced latency:** a raw change is first sampled at edge 0. The debounced level changes at edge DEB_CYCLES+1, provided the raw level holds stable.
- **Raw-to-pulse latency:** the final beam-clear event produces its pulse, registered at edge DEB_CYCLES+2. With DEB_CYCLES=4 this is edge 6, so the pulse is high during cycle 7.
- **Glitch rejection:** any glitch shorter than DEB_CYCLES synchronized cycles is fully rejected.
- **Back-to-back passages:** a new passage may begin in the cycle after a pulse.
- **Reset timing:** reset asserted at edge k forces every reset value at edge k. The first sampled input after deassertion is the one at edge k+1.

## Configuration
- **DOOR_FAULT_EN defined:**
  - A timeout counter of width $clog2(TIMEOUT_CYCLES+1) runs in O1, OI_E, I2, I1, OI_X and O2.
  - It clears on every state change and in IDLE and WAIT_CLEAR.
  - When it reaches TIMEOUT_CYCLES, the FSM → WAIT_CLEAR and FAULT pulses for one cycle. No PUSH pulse is generated.
- **DOOR_FAULT_EN undefined:**
  - No timeout counter; FAULT is constant 0.
  - The FSM may stay in any state indefinitely.

## Test plan
- **Clean entry** (DEB=4): OUT=1 for 10 cycles, then OUT=1 and IN=1 for 10, then IN=1 only for 10, then both 0 → exactly one PUSH_UP pulse, 6 edges after both clear; PUSH_DOWN stays 0.
- **Clean exit:** the mirror sequence IN, then both, then OUT, then clear → exactly one PUSH_DOWN pulse and no PUSH_UP.
- **Back-out and glitches:**
  - OUT, then both, then OUT only, then clear → no pulse.
  - 3-cycle pulses on IN while idle → deb never changes and no pulse.
- **Ambiguous and simultaneous cases:**
  - Both beams rise together from IDLE, then clear → no pulse; the FSM passes through WAIT_CLEAR.
  - Both beams clear together from OI_E → no pulse.
- **Timeout** (DOOR_FAULT_EN, TIMEOUT=20): hold OUT=1 for 40 cycles → FAULT pulses once, and clearing afterwards yields no PUSH_UP. Without the macro, FAULT stays 0.
- **Reset:** reset asserted while in I2 with IN=1 → outputs 0 and state IDLE on the next edge; releasing both beams produces no pulse.

Source files
------------

// File: rtl/door_sensor_fsm_if.sv
// Door sensor bundle: raw photo-beam inputs in, registered count pulses and
// FSM state out. Pulses are single-cycle strobes with no backpressure.
interface door_sensor_fsm_if;
  logic       SENSOR_OUT;
  logic       SENSOR_IN;
  logic       PUSH_UP;
  logic       PUSH_DOWN;
  logic       FAULT;
  // Debug view of the sequencing FSM:
  // 0 IDLE, 1 O1, 2 OI_E, 3 I2, 4 I1, 5 OI_X, 6 O2, 7 WAIT_CLEAR
  logic [2:0] state_dbg;

  modport master (
    output SENSOR_OUT, SENSOR_IN,
    input  PUSH_UP, PUSH_DOWN, FAULT, state_dbg
  );

  modport slave (
    input  SENSOR_OUT, SENSOR_IN,
    output PUSH_UP, PUSH_DOWN, FAULT, state_dbg
  );
endinterface

// File: rtl/door_sensor_fsm.sv
// Door front-end: sync + debounce two beams, sequence them into PUSH_UP/PUSH_DOWN.
// Optional sequence timeout with FAULT pulse is enabled by defining DOOR_FAULT_EN.
module door_sensor_fsm #(
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          reset,
  door_sensor_fsm_if.slave bus
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("door_sensor_fsm: DEB_CYCLES must be 1..255 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    O1         = 3'd1,
    OI_E       = 3'd2,
    I2         = 3'd3,
    I1         = 3'd4,
    OI_X       = 3'd5,
    O2         = 3'd6,
    WAIT_CLEAR = 3'd7
  } state_t;

  // Index 0 is the outer beam, index 1 the inner beam.
  logic [1:0]    sync_a;
  logic [1:0]    sync_s;
  logic [1:0]    deb;
  logic [CW-1:0] cnt [2];

  state_t state, state_n;
  logic   up_n, down_n;
  logic   up_q, down_q;
  logic   o, i;
  logic   tmo_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 2'b00;
      sync_s <= 2'b00;
    end else begin
      sync_a <= {bus.SENSOR_IN, bus.SENSOR_OUT};
      sync_s <= sync_a;
    end
  end

  // Level changes only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= 2'b00;
      for (int k = 0; k < 2; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (sync_s[k] == deb[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CW'(DEB_CYCLES - 1)) begin
          deb[k] <= sync_s[k];
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  assign o = deb[0];
  assign i = deb[1];

`ifdef DOOR_FAULT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic          timed;
  logic [TW-1:0] tmo;
  logic          fault_q;

  assign timed   = (state != IDLE) && (state != WAIT_CLEAR);
  assign tmo_hit = timed && (tmo == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset || !timed || (state_n != state)) tmo <= '0;
    else                                       tmo <= tmo + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= tmo_hit;
  end

  assign bus.FAULT = fault_q;
`else
  assign tmo_hit   = 1'b0;
  assign bus.FAULT = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      state  <= state_n;
      up_q   <= up_n;
      down_q <= down_n;
    end
  end

  // Opposite-single-beam jumps (O only <-> I only) are ignored: they skip
  // the both-blocked phase, so direction cannot be trusted.
  always_comb begin
    state_n = state;
    up_n    = 1'b0;
    down_n  = 1'b0;
    case (state)
      IDLE: begin
        if (o && !i)      state_n = O1;
        else if (!o && i) state_n = I1;
        else if (o && i)  state_n = WAIT_CLEAR;
      end
      O1: begin
        if (o && i)        state_n = OI_E;
        else if (!o && !i) state_n = IDLE;
      end
      OI_E: begin
        if (!o && i)       state_n = I2;
        else if (o && !i)  state_n = O1;
        else if (!o && !i) state_n = IDLE;
      end
      I2: begin
        if (!o && !i) begin
          state_n = IDLE;
          up_n    = 1'b1;
        end else if (o && i) begin
          state_n = OI_E;
        end
      end
      I1: begin
        if (o && i)        state_n = OI_X;
        else if (!o && !i) state_n = IDLE;
      end
      OI_X: begin
        if (o && !i)       state_n = O2;
        else if (!o && i)  state_n = I1;
        else if (!o && !i) state_n = IDLE;
      end
      O2: begin
        if (!o && !i) begin
          state_n = IDLE;
          down_n  = 1'b1;
        end else if (o && i) begin
          state_n = OI_X;
        end
      end
      WAIT_CLEAR: begin
        if (!o && !i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A stalled sequence is abandoned; the passage is not counted.
    if (tmo_hit) begin
      state_n = WAIT_CLEAR;
      up_n    = 1'b0;
      down_n  = 1'b0;
    end
  end

  assign bus.PUSH_UP   = up_q;
  assign bus.PUSH_DOWN = down_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_door_sensor_fsm.sv
// Bench for door_sensor_fsm: directed passages plus randomized beam activity,
// compared every cycle against a pattern-level reference model.
module tb_door_sensor_fsm;

  localparam int DEB = 4;
  localparam int TMO = 20;

  logic clk;
  logic reset;
  door_sensor_fsm_if bus ();

  door_sensor_fsm #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int tot_up   = 0;
  int tot_dn   = 0;
  int tot_flt  = 0;

  // Reference model: sync pipeline, debounced levels from a sample window,
  // and passage tracking as (direction, last accepted beam pattern {O,I}).
  logic     m_s1 [2];
  logic     m_s2 [2];
  logic     m_deb [2];
  logic     hq [2][$];
  int       mode;        // 0 none, 1 entering, 2 exiting, 3 waiting for clear
  logic [1:0] pos;
  int       tmo_run;
  logic     exp_up, exp_dn, exp_flt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 1'b0; m_s2[k] = 1'b0; m_deb[k] = 1'b0;
      hq[k].delete();
    end
    mode = 0; pos = 2'b00; tmo_run = 0;
    exp_up = 1'b0; exp_dn = 1'b0; exp_flt = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic ro, input logic ri);
    logic [1:0] pat;
    int         old_mode;
    logic [1:0] old_pos;
    logic       all_diff;
    if (r) begin
      model_reset();
      return;
    end
    pat = {m_deb[0], m_deb[1]};
    exp_up = 1'b0; exp_dn = 1'b0; exp_flt = 1'b0;
    old_mode = mode; old_pos = pos;
    case (mode)
      0: begin
        if (pat == 2'b10)      begin mode = 1; pos = pat; end
        else if (pat == 2'b01) begin mode = 2; pos = pat; end
        else if (pat == 2'b11) mode = 3;
      end
      3: if (pat == 2'b00) mode = 0;
      default: begin
        if (pat != pos) begin
          if (pat == 2'b00) begin
            exp_up = (mode == 1) && (pos == 2'b01);
            exp_dn = (mode == 2) && (pos == 2'b10);
            mode = 0;
          end else if (pat == 2'b11 || pos == 2'b11) begin
            pos = pat;
          end
        end
      end
    endcase
`ifdef DOOR_FAULT_EN
    if ((old_mode == 1 || old_mode == 2) && tmo_run == TMO) begin
      mode = 3; exp_up = 1'b0; exp_dn = 1'b0; exp_flt = 1'b1; tmo_run = 0;
    end else if ((old_mode == 1 || old_mode == 2) && mode == old_mode && pos == old_pos) begin
      tmo_run++;
    end else begin
      tmo_run = 0;
    end
`endif
    for (int k = 0; k < 2; k++) begin
      hq[k].push_back(m_s2[k]);
      if (hq[k].size() > DEB) void'(hq[k].pop_front());
      all_diff = (hq[k].size() == DEB);
      foreach (hq[k][j]) if (hq[k][j] == m_deb[k]) all_diff = 1'b0;
      if (all_diff) m_deb[k] = ~m_deb[k];
    end
    m_s2[0] = m_s1[0]; m_s2[1] = m_s1[1];
    m_s1[0] = ro;      m_s1[1] = ri;
  endtask

  // One clock: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input logic o, input logic i, input logic r);
    bus.SENSOR_OUT = o;
    bus.SENSOR_IN  = i;
    reset          = r;
    @(posedge clk);
    model_edge(r, o, i);
    #1;
    check("push_up",   bus.PUSH_UP,   exp_up);
    check("push_down", bus.PUSH_DOWN, exp_dn);
    check("fault",     bus.FAULT,     exp_flt);
    tot_up  += int'(bus.PUSH_UP);
    tot_dn  += int'(bus.PUSH_DOWN);
    tot_flt += int'(bus.FAULT);
    @(negedge clk);
  endtask

  task automatic hold(input logic o, input logic i, input int n);
    for (int c = 0; c < n; c++) cycle(o, i, 1'b0);
  endtask

  int up0, dn0, flt0, lat, kind;

  initial begin
    bus.SENSOR_OUT = 1'b0;
    bus.SENSOR_IN  = 1'b0;
    reset          = 1'b1;
    model_reset();
    @(negedge clk);

    // Reset state
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("reset_state_idle", bus.state_dbg, 3'd0);
    check("reset_deb", dut.deb, 2'b00);
    hold(1'b0, 1'b0, 3);

    // Clean entry with pulse latency from the final beam clear
    up0 = tot_up; dn0 = tot_dn;
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (bus.PUSH_UP === 1'b1 && lat < 0) lat = c;
    end
    check("entry_latency", lat, 6);
    check("entry_up_count", tot_up - up0, 1);
    check("entry_down_count", tot_dn - dn0, 0);

    // Clean exit
    up0 = tot_up; dn0 = tot_dn;
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 12);
    check("exit_down_count", tot_dn - dn0, 1);
    check("exit_up_count", tot_up - up0, 0);

    // Back-out after reaching both-blocked
    up0 = tot_up; dn0 = tot_dn;
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 12);
    check("backout_pulses", (tot_up - up0) + (tot_dn - dn0), 0);

    // Short IN glitches while idle
    up0 = tot_up; dn0 = tot_dn;
    for (int g = 0; g < 3; g++) begin
      hold(1'b0, 1'b1, 3);
      hold(1'b0, 1'b0, 5);
      check("glitch_deb", dut.deb, 2'b00);
    end
    check("glitch_pulses", (tot_up - up0) + (tot_dn - dn0), 0);
    check("glitch_state_idle", bus.state_dbg, 3'd0);

    // Both beams rise together
    up0 = tot_up; dn0 = tot_dn;
    hold(1'b1, 1'b1, 10);
    check("both_rise_wait_clear", bus.state_dbg, 3'd7);
    hold(1'b0, 1'b0, 12);
    check("both_rise_pulses", (tot_up - up0) + (tot_dn - dn0), 0);
    check("both_rise_back_idle", bus.state_dbg, 3'd0);

    // Both clear together from the both-blocked entry phase
    up0 = tot_up; dn0 = tot_dn;
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b0, 12);
    check("both_clear_pulses", (tot_up - up0) + (tot_dn - dn0), 0);

    // Long OUT hold: faults only with the timeout feature
    up0 = tot_up; flt0 = tot_flt;
    hold(1'b1, 1'b0, 40);
    hold(1'b0, 1'b0, 12);
`ifdef DOOR_FAULT_EN
    check("timeout_fault_count", tot_flt - flt0, 1);
`else
    check("timeout_fault_count", tot_flt - flt0, 0);
`endif
    check("timeout_up_count", tot_up - up0, 0);

    // Reset in the inner-only entry phase discards the passage
    up0 = tot_up; dn0 = tot_dn;
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    cycle(1'b0, 1'b1, 1'b1);
    check("midreset_state", bus.state_dbg, 3'd0);
    hold(1'b0, 1'b1, 5);
    hold(1'b0, 1'b0, 15);
    check("midreset_pulses", (tot_up - up0) + (tot_dn - dn0), 0);

    // Randomized activity: arbitrary patterns, glitches, full passages, resets
    for (int s = 0; s < 250; s++) begin
      kind = $urandom_range(0, 19);
      if (kind < 11) begin
        hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
      end else if (kind < 15) begin
        hold(1'b1, 1'b0, $urandom_range(3, 10));
        hold(1'b1, 1'b1, $urandom_range(3, 10));
        hold(1'b0, 1'b1, $urandom_range(3, 10));
        hold(1'b0, 1'b0, $urandom_range(3, 10));
      end else if (kind < 19) begin
        hold(1'b0, 1'b1, $urandom_range(3, 10));
        hold(1'b1, 1'b1, $urandom_range(3, 10));
        hold(1'b1, 1'b0, $urandom_range(3, 10));
        hold(1'b0, 1'b0, $urandom_range(3, 10));
      end else begin
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      end
    end
    hold(1'b0, 1'b0, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
